// File: rtl/fb_write_arbiter_if.sv
// Pixel-write bus between the drawing engines (master) and the framebuffer write arbiter (slave).
// Requester i drives bit i of the per-requester vectors and slice [i*W +: W] of the packed coordinates.
interface fb_write_arbiter_if #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned X_W     = 11,
   parameter int unsigned Y_W     = 11
);
   localparam int unsigned OwW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [NUM_REQ-1:0]     req;
   logic [NUM_REQ-1:0]     req_last;
   logic [NUM_REQ*X_W-1:0] req_x;
   logic [NUM_REQ*Y_W-1:0] req_y;
   logic [NUM_REQ-1:0]     req_color;
   logic [NUM_REQ-1:0]     gnt;
   logic                   busy;
   logic [OwW-1:0]         owner;
   logic [X_W-1:0]         fb_x;
   logic [Y_W-1:0]         fb_y;
   logic                   fb_color;
   logic                   fb_write;

   modport master (
      output req, req_last, req_x, req_y, req_color,
      input  gnt, busy, owner, fb_x, fb_y, fb_color, fb_write
   );

   modport slave (
      input  req, req_last, req_x, req_y, req_color,
      output gnt, busy, owner, fb_x, fb_y, fb_color, fb_write
   );
endinterface

// File: rtl/fb_write_arbiter.sv
// Framebuffer write-port arbiter: grants one drawing engine per primitive and registers its pixels.
// Define ARB_RR_EN for round-robin arbitration; the default is fixed priority (index 0 highest).
module fb_write_arbiter #(
   parameter int unsigned NUM_REQ   = 4,
   parameter int unsigned X_W       = 11,
   parameter int unsigned Y_W       = 11,
   parameter int unsigned MAX_BURST = 0
) (
   input logic               clk_i,
   input logic               rst_ni,
   fb_write_arbiter_if.slave arb_if
);
   localparam int unsigned OwW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int unsigned CntW = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;

   typedef enum logic [0:0] {StIdle, StGrant} state_e;

   state_e             state_q, state_d;
   logic [NUM_REQ-1:0] gnt_q, gnt_d;
   logic [OwW-1:0]     owner_q, owner_d;
   logic [CntW-1:0]    cnt_q, cnt_d;
   logic [X_W-1:0]     fb_x_q, fb_x_d;
   logic [Y_W-1:0]     fb_y_q, fb_y_d;
   logic               fb_color_q, fb_color_d;
   logic               fb_write_q, fb_write_d;
   logic [OwW-1:0]     win;
   logic               win_vld;
   logic               accept;
   logic               hit_max;
   logic               release_now;

`ifdef ARB_RR_EN
   logic [OwW-1:0] rr_q, rr_d;

   // Search starts just after the last owner so it ends up with the lowest priority.
   always_comb begin
      win     = '0;
      win_vld = 1'b0;
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
         if (!win_vld && arb_if.req[(32'(rr_q) + k) % NUM_REQ]) begin
            win     = OwW'((32'(rr_q) + k) % NUM_REQ);
            win_vld = 1'b1;
         end
      end
   end
`else
   always_comb begin
      win     = '0;
      win_vld = 1'b0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (arb_if.req[i]) begin
            win     = OwW'(i);
            win_vld = 1'b1;
         end
      end
   end
`endif

   assign accept  = arb_if.req[owner_q] & gnt_q[owner_q];
   assign hit_max = (MAX_BURST != 0) && ((32'(cnt_q) + 32'd1) == MAX_BURST);
   assign release_now = !arb_if.req[owner_q] ||
                        (accept && (arb_if.req_last[owner_q] || hit_max));

   always_comb begin
      state_d    = state_q;
      gnt_d      = gnt_q;
      owner_d    = owner_q;
      cnt_d      = cnt_q;
      fb_x_d     = fb_x_q;
      fb_y_d     = fb_y_q;
      fb_color_d = fb_color_q;
      fb_write_d = 1'b0;
`ifdef ARB_RR_EN
      rr_d       = rr_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (win_vld) begin
               state_d = StGrant;
               gnt_d   = NUM_REQ'(1) << win;
               owner_d = win;
               cnt_d   = '0;
            end
         end
         StGrant: begin
            if (accept) begin
               fb_x_d     = arb_if.req_x[owner_q*X_W +: X_W];
               fb_y_d     = arb_if.req_y[owner_q*Y_W +: Y_W];
               fb_color_d = arb_if.req_color[owner_q];
               fb_write_d = 1'b1;
               cnt_d      = cnt_q + CntW'(1);
            end
            // Release always passes through StIdle, giving everyone a fresh arbitration.
            if (release_now) begin
               state_d = StIdle;
               gnt_d   = '0;
`ifdef ARB_RR_EN
               rr_d    = owner_q;
`endif
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= StIdle;
         gnt_q      <= '0;
         owner_q    <= '0;
         cnt_q      <= '0;
         fb_x_q     <= '0;
         fb_y_q     <= '0;
         fb_color_q <= 1'b0;
         fb_write_q <= 1'b0;
`ifdef ARB_RR_EN
         rr_q       <= '0;
`endif
      end else begin
         state_q    <= state_d;
         gnt_q      <= gnt_d;
         owner_q    <= owner_d;
         cnt_q      <= cnt_d;
         fb_x_q     <= fb_x_d;
         fb_y_q     <= fb_y_d;
         fb_color_q <= fb_color_d;
         fb_write_q <= fb_write_d;
`ifdef ARB_RR_EN
         rr_q       <= rr_d;
`endif
      end
   end

   assign arb_if.gnt      = gnt_q;
   assign arb_if.busy     = (state_q == StGrant);
   assign arb_if.owner    = owner_q;
   assign arb_if.fb_x     = fb_x_q;
   assign arb_if.fb_y     = fb_y_q;
   assign arb_if.fb_color = fb_color_q;
   assign arb_if.fb_write = fb_write_q;
endmodule

// File: tb/tb_fb_write_arbiter.sv
// Bench for fb_write_arbiter: a directed vector table plus hand-written burst, round-robin,
// max-burst and asynchronous-reset sequences. dut0 has unlimited bursts, dut1 MAX_BURST=4.
module tb_fb_write_arbiter;
   logic        clk;
   logic        rst_n;
   logic [3:0]  req0, last0, col0, req1, last1, col1;
   logic [10:0] xv0, yv0, xv1, yv1;
   logic [43:0] x0_pk, y0_pk, x1_pk, y1_pk;
   int          n_chk;
   int          n_pass;

   typedef struct {
      logic [3:0]  req;
      logic [3:0]  last;
      logic [3:0]  col;
      logic [10:0] xv;
      logic [10:0] yv;
      logic [3:0]  e_gnt;
      logic        e_busy;
      logic [1:0]  e_own;
      logic        e_wr;
      logic [10:0] e_x;
      logic [10:0] e_y;
      logic        e_c;
   } vec_t;

   vec_t tbl[9];
   int   exp_own[5];

   fb_write_arbiter_if #(.NUM_REQ(4), .X_W(11), .Y_W(11)) bus0 ();
   fb_write_arbiter_if #(.NUM_REQ(4), .X_W(11), .Y_W(11)) bus1 ();

   fb_write_arbiter #(.NUM_REQ(4), .X_W(11), .Y_W(11), .MAX_BURST(0)) dut0 (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .arb_if (bus0)
   );

   fb_write_arbiter #(.NUM_REQ(4), .X_W(11), .Y_W(11), .MAX_BURST(4)) dut1 (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .arb_if (bus1)
   );

   // Requester i sees x = xv + 64*i and y = yv + 32*i, so a wrong slice shows up in fb_x/fb_y.
   always_comb begin
      x0_pk = '0;
      y0_pk = '0;
      x1_pk = '0;
      y1_pk = '0;
      for (int i = 0; i < 4; i++) begin
         x0_pk[i*11 +: 11] = xv0 + 11'(i * 64);
         y0_pk[i*11 +: 11] = yv0 + 11'(i * 32);
         x1_pk[i*11 +: 11] = xv1 + 11'(i * 64);
         y1_pk[i*11 +: 11] = yv1 + 11'(i * 32);
      end
   end

   assign bus0.req       = req0;
   assign bus0.req_last  = last0;
   assign bus0.req_color = col0;
   assign bus0.req_x     = x0_pk;
   assign bus0.req_y     = y0_pk;
   assign bus1.req       = req1;
   assign bus1.req_last  = last1;
   assign bus1.req_color = col1;
   assign bus1.req_x     = x1_pk;
   assign bus1.req_y     = y1_pk;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h want %0h", name, act, exp);
   endtask

   task automatic clear_inputs();
      req0 = '0; last0 = '0; col0 = '0; xv0 = '0; yv0 = '0;
      req1 = '0; last1 = '0; col1 = '0; xv1 = '0; yv1 = '0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      clear_inputs();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      n_chk  = 0;
      n_pass = 0;
      rst_n  = 1'b0;
      clear_inputs();
`ifdef ARB_RR_EN
      exp_own = '{1, 2, 3, 0, 1};
`else
      exp_own = '{0, 0, 0, 0, 0};
`endif
      //         req    last   col    xv  yv  gnt    bsy own wr  x    y   c
      tbl[0] = '{4'h4, 4'h4, 4'h4, 5, 7, 4'h4, 1, 2, 0, 0,   0,  0};
      tbl[1] = '{4'h4, 4'h4, 4'h4, 5, 7, 4'h0, 0, 2, 1, 133, 71, 1};
      tbl[2] = '{4'h0, 4'h0, 4'h0, 5, 7, 4'h0, 0, 2, 0, 0,   0,  0};
      tbl[3] = '{4'h1, 4'h0, 4'h2, 5, 7, 4'h1, 1, 0, 0, 0,   0,  0};
      tbl[4] = '{4'h3, 4'h0, 4'h2, 5, 7, 4'h1, 1, 0, 1, 5,   7,  0};
      tbl[5] = '{4'h2, 4'h0, 4'h2, 5, 7, 4'h0, 0, 0, 0, 0,   0,  0};
      tbl[6] = '{4'h2, 4'h0, 4'h2, 5, 7, 4'h2, 1, 1, 0, 0,   0,  0};
      tbl[7] = '{4'h2, 4'h2, 4'h2, 5, 7, 4'h0, 0, 1, 1, 69,  39, 1};
      tbl[8] = '{4'h0, 4'h0, 4'h0, 5, 7, 4'h0, 0, 1, 0, 0,   0,  0};

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("reset_ctl", {bus0.gnt, bus0.busy, bus0.owner, bus0.fb_write}, 64'h0);
      chk("reset_pix", {bus0.fb_x, bus0.fb_y, bus0.fb_color}, 64'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // Single pixel, owner abandon, waiting requester
      for (int r = 0; r < 9; r++) begin
         @(negedge clk);
         req0 = tbl[r].req; last0 = tbl[r].last; col0 = tbl[r].col;
         xv0  = tbl[r].xv;  yv0   = tbl[r].yv;
         @(posedge clk);
         #1;
         chk($sformatf("tbl%0d_ctl", r), {bus0.gnt, bus0.busy, bus0.owner, bus0.fb_write},
             {tbl[r].e_gnt, tbl[r].e_busy, tbl[r].e_own, tbl[r].e_wr});
         if (tbl[r].e_wr)
            chk($sformatf("tbl%0d_pix", r), {bus0.fb_x, bus0.fb_y, bus0.fb_color},
                {tbl[r].e_x, tbl[r].e_y, tbl[r].e_c});
      end

      // 10-pixel burst from requester 0 with requester 1 waiting
      do_reset();
      req0 = 4'h1; xv0 = 11'd100; col0 = 4'h1;
      @(posedge clk);
      #1;
      chk("burst_gnt0", {bus0.gnt, bus0.owner}, {4'h1, 2'd0});
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         req0 = 4'h3; xv0 = 11'(100 + k); last0 = (k == 9) ? 4'h1 : 4'h0;
         @(posedge clk);
         #1;
         chk($sformatf("burst_px%0d", k), {bus0.fb_write, bus0.fb_x, bus0.owner},
             {1'b1, 11'(100 + k), 2'd0});
      end
      chk("burst_rel", {bus0.gnt, bus0.busy}, {4'h0, 1'b0});
      @(negedge clk);
      req0 = 4'h2; last0 = 4'h0;
      @(posedge clk);
      #1;
      chk("burst_next", {bus0.gnt, bus0.owner, bus0.fb_write}, {4'h2, 2'd1, 1'b0});

      // Back-to-back single-pixel bursts with all requesters active
      do_reset();
      req0 = 4'hf; last0 = 4'hf;
      for (int g = 0; g < 5; g++) begin
         @(posedge clk);
         #1;
         chk($sformatf("rr_gnt%0d", g), {bus0.gnt, bus0.owner},
             {4'(1 << exp_own[g]), 2'(exp_own[g])});
         @(posedge clk);
         #1;
         chk($sformatf("rr_wr%0d", g), {bus0.fb_write, bus0.gnt, bus0.busy},
             {1'b1, 4'h0, 1'b0});
      end

      // MAX_BURST=4: six pixels without last, split into 4 + 2
      do_reset();
      req1 = 4'h8; xv1 = 11'd0;
      @(posedge clk);
      #1;
      chk("mb_gnt", bus1.gnt, 4'h8);
      for (int k = 0; k < 6; k++) begin
         if (k == 4) begin
            @(posedge clk);
            #1;
            chk("mb_regrant", {bus1.gnt, bus1.fb_write}, {4'h8, 1'b0});
         end
         @(negedge clk);
         xv1 = 11'(k);
         @(posedge clk);
         #1;
         chk($sformatf("mb_px%0d", k), {bus1.fb_write, bus1.fb_x}, {1'b1, 11'(k + 192)});
         if (k == 3) chk("mb_rel", {bus1.gnt, bus1.busy}, {4'h0, 1'b0});
      end
      chk("mb_hold", {bus1.gnt, bus1.busy}, {4'h8, 1'b1});
      @(negedge clk);
      req1 = 4'h0;
      @(posedge clk);
      #1;
      chk("mb_drop", {bus1.gnt, bus1.busy, bus1.fb_write}, {4'h0, 1'b0, 1'b0});

      // Asynchronous reset on the third pixel of a burst
      do_reset();
      req0 = 4'h4; xv0 = 11'd10;
      @(posedge clk);
      for (int p = 1; p <= 3; p++) begin
         @(negedge clk);
         xv0 = 11'(10 + p);
         @(posedge clk);
      end
      #1;
      chk("ar_px3", {bus0.fb_write, bus0.fb_x, bus0.owner}, {1'b1, 11'd141, 2'd2});
      rst_n = 1'b0;
      #1;
      chk("ar_async", {bus0.gnt, bus0.fb_write, bus0.busy, bus0.owner}, 64'h0);
      @(negedge clk);
      clear_inputs();
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("ar_idle", {bus0.gnt, bus0.fb_write, bus0.busy, bus0.owner}, 64'h0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
